// File: rtl/uart_prog_loader.sv
// UART boot-loader front end: deframes host bytes into 32-bit ROM/RAM upload writes and answers ACK/NAK on tx.
// Latency: upg_wen_o rises 2 cycles after the stop-bit centre of a word's 4th byte; a response starts on tx within 2 cycles.
// Backpressure: none; the host paces the link, and a newer response overwrites a pending unsent one.
module uart_prog_loader #(
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o
);
  localparam int CPB    = CLK_FREQ / BAUD;
  localparam int CW     = $clog2(CPB + 1);
  localparam int TO_CYC = TIMEOUT_BITS * CPB;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TO_CYC);
  localparam logic [7:0]    ACK     = 8'h06;
  localparam logic [7:0]    NAK     = 8'h15;

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2;
  logic            rx_busy, rx_valid, frame_err;
  logic [3:0]      rx_bit;
  logic [CW-1:0]   rx_cnt;
  logic [7:0]      rx_sh;
  logic            resp_vld;
  logic [7:0]      resp_byte;
  logic            pend_vld;
  logic [7:0]      pend_byte;
  logic [9:0]      tx_sh;
  logic [3:0]      tx_bits;
  logic [CW-1:0]   tx_cnt;
  logic            target;
  logic [7:0]      cnt_lo;
  logic [14:0]     cnt_n;
  logic [13:0]     word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     word_sr;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     n_rx;
  logic            seg_active, abort, last_word;

  assign n_rx       = {rx_sh, cnt_lo};
  assign seg_active = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
  assign abort      = seg_active && !rx_valid && (frame_err || (to_cnt == TO_MAX));
  assign last_word  = ({1'b0, word_idx} + 15'd1) == cnt_n;
  assign upg_done_o = (state == DONE);
  assign tx         = tx_sh[0];

  // Two-flop synchronizer for the asynchronous rx line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Receiver: confirm start at half a bit, then sample data and stop at bit centres
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy   <= 1'b0;
      rx_bit    <= 4'd0;
      rx_cnt    <= '0;
      rx_sh     <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s2) begin
          rx_busy <= 1'b1;
          rx_bit  <= 4'd0;
          rx_cnt  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_M1) begin
          rx_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;  // line back high: glitch, not a start bit
          else       rx_bit  <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == CPB_M1) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy   <= 1'b0;
          rx_valid  <= rx_s2;
          frame_err <= !rx_s2;
        end else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // Loader state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, write strobe and response requests
  always_comb begin
    state_nxt = state;
    resp_vld  = 1'b0;
    resp_byte = ACK;
    upg_wen_o = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_sh == 8'h01 || rx_sh == 8'h02) begin
          state_nxt = CNT_LO;
        end else if (rx_sh == 8'hFF) begin
          state_nxt = DONE;
          resp_vld  = 1'b1;
        end else begin
          resp_vld  = 1'b1;
          resp_byte = NAK;
        end
      end
      CNT_LO: if (rx_valid) state_nxt = CNT_HI;
      CNT_HI: if (rx_valid) begin
        if (n_rx == 16'd0) begin
          state_nxt = IDLE;
          resp_vld  = 1'b1;
        end else if (n_rx > 16'd16384) begin
          state_nxt = IDLE;
          resp_vld  = 1'b1;
          resp_byte = NAK;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: if (rx_valid && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE: begin
        upg_wen_o = 1'b1;
        if (last_word) begin
          state_nxt = IDLE;
          resp_vld  = 1'b1;
        end else begin
          state_nxt = DATA;
        end
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      resp_vld  = 1'b1;
      resp_byte = NAK;
    end
  end

  // Segment datapath; address/data outputs load on entry to WRITE and hold until the next word
  always_ff @(posedge clk) begin
    if (rst) begin
      target    <= 1'b0;
      cnt_lo    <= 8'd0;
      cnt_n     <= 15'd0;
      word_idx  <= 14'd0;
      byte_idx  <= 2'd0;
      word_sr   <= 24'd0;
      upg_adr_o <= 15'd0;
      upg_dat_o <= 32'd0;
    end else begin
      case (state)
        IDLE:   if (rx_valid && (rx_sh == 8'h01 || rx_sh == 8'h02)) target <= rx_sh[1];
        CNT_LO: if (rx_valid) cnt_lo <= rx_sh;
        CNT_HI: if (rx_valid) begin
          cnt_n    <= n_rx[14:0];
          word_idx <= 14'd0;
          byte_idx <= 2'd0;
        end
        DATA: if (rx_valid) begin
          word_sr  <= {rx_sh, word_sr[23:8]};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            upg_adr_o <= {target, word_idx};
            upg_dat_o <= {rx_sh, word_sr};
          end
        end
        WRITE:  word_idx <= word_idx + 14'd1;
        default: ;
      endcase
    end
  end

  // Inactivity timer, live only while a segment is open
  always_ff @(posedge clk) begin
    if (rst || !seg_active || rx_valid) to_cnt <= '0;
    else if (to_cnt != TO_MAX)          to_cnt <= to_cnt + TW'(1);
  end

  // Transmitter: one-deep pending byte feeding an 8N1 shifter that never truncates a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_byte <= 8'd0;
      tx_sh     <= '1;
      tx_bits   <= 4'd0;
      tx_cnt    <= '0;
    end else begin
      if (resp_vld) begin
        pend_vld  <= 1'b1;
        pend_byte <= resp_byte;
      end else if (tx_bits == 4'd0 && pend_vld) begin
        pend_vld <= 1'b0;
      end
      if (tx_bits == 4'd0) begin
        if (pend_vld) begin
          tx_sh   <= {1'b1, pend_byte, 1'b0};
          tx_bits <= 4'd10;
          tx_cnt  <= '0;
        end
      end else if (tx_cnt == CPB_M1) begin
        tx_cnt  <= '0;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bits <= tx_bits - 4'd1;
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed host byte streams at 16 clocks/bit, scoreboarded writes and tx responses.
// Latency: writes and responses are matched in order as they appear, not at fixed cycles.
// Backpressure: none; the bench waits for expected traffic to drain with bounded budgets.
module tb_uart_prog_loader;
  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        tx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] bq[$];
  wr_t        e;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         wr_seen = 0;
  int         tx_seen = 0;
  int         wr_before, tx_before;
  logic [31:0] w;

  uart_prog_loader #(.CLK_FREQ(1600), .BAUD(100), .TIMEOUT_BITS(2048)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_q();
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    bq.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_tx.size() == 0 && exp_wr.size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    exp_wr.delete();
    @(negedge clk);
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && upg_wen_o) begin
      wr_seen++;
      chk("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        chk("wr_adr", upg_adr_o, e.adr);
        chk("wr_dat", upg_dat_o, e.dat);
      end
    end
  end

  // Serial decoder on tx: each frame is scored against the oldest expected response
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx;
        end
        repeat (16) @(negedge clk);
        tx_seen++;
        chk("tx_stop", tx, 1);
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", b, exp_tx.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    do_reset();

    // Reset state
    chk("rst_tx", tx, 1);
    chk("rst_wen", upg_wen_o, 0);
    chk("rst_adr", upg_adr_o, 0);
    chk("rst_dat", upg_dat_o, 0);
    chk("rst_done", upg_done_o, 0);

    // ROM upload of two words
    exp_wr.push_back({15'h0000, 32'h12345678});
    exp_wr.push_back({15'h0001, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    bq = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q();
    wait_drain("rom", 1000);
    chk("rom_wr_count", wr_seen, 2);
    chk("rom_done", upg_done_o, 0);
    chk("rom_hold_adr", upg_adr_o, 15'h0001);
    chk("rom_hold_dat", upg_dat_o, 32'hDEADBEEF);

    // Reset during the 3rd data byte, then a fresh upload
    bq = '{8'h01, 8'h02, 8'h00, 8'hAA, 8'hBB};
    send_q();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_wen", upg_wen_o, 0);
    chk("mid_rst_adr", upg_adr_o, 0);
    chk("mid_rst_dat", upg_dat_o, 0);
    chk("mid_rst_done", upg_done_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_wr.push_back({15'h0000, 32'h44332211});
    exp_tx.push_back(8'h06);
    bq = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q();
    wait_drain("fresh", 1000);

    // Bad command, oversize count, zero count
    wr_before = wr_seen;
    exp_tx.push_back(8'h15);
    bq = '{8'h07};
    send_q();
    wait_drain("badcmd", 1000);
    exp_tx.push_back(8'h15);
    bq = '{8'h01, 8'h01, 8'h40};
    send_q();
    wait_drain("bigcnt", 1000);
    exp_tx.push_back(8'h06);
    bq = '{8'h01, 8'h00, 8'h00};
    send_q();
    wait_drain("zerocnt", 1000);
    chk("bad_no_wr", wr_seen, wr_before);

    // 8-clock glitch on rx must not produce a byte
    tx_before = tx_seen;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_tx", tx_seen, tx_before);
    chk("glitch_done", upg_done_o, 0);

    // Framing error inside DATA, then a clean upload proves the FSM is back in IDLE
    wr_before = wr_seen;
    bq = '{8'h01, 8'h01, 8'h00, 8'h11};
    send_q();
    exp_tx.push_back(8'h15);
    send_byte(8'h22, 1'b0);
    wait_drain("frame", 1000);
    chk("frame_no_wr", wr_seen, wr_before);
    exp_wr.push_back({15'h0000, 32'hCAFEF00D});
    exp_tx.push_back(8'h06);
    bq = '{8'h01, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_q();
    wait_drain("recover", 1000);

    // Back-to-back 16-word ROM upload with no inter-byte gap
    wr_before = wr_seen;
    tx_before = tx_seen;
    bq = '{8'h01, 8'h10, 8'h00};
    for (int i = 0; i < 16; i++) begin
      w = 32'hA5C30000 ^ (i * 32'h01010101);
      exp_wr.push_back({15'(i), w});
      for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    end
    exp_tx.push_back(8'h06);
    send_q();
    wait_drain("b2b", 1000);
    chk("b2b_wr_count", wr_seen - wr_before, 16);
    chk("b2b_one_ack", tx_seen - tx_before, 1);

    // RAM upload, end command, then ignored traffic
    exp_wr.push_back({15'h4000, 32'h01020304});
    exp_tx.push_back(8'h06);
    bq = '{8'h02, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    send_q();
    wait_drain("ram", 1000);
    chk("ram_done_before_end", upg_done_o, 0);
    exp_tx.push_back(8'h06);
    bq = '{8'hFF};
    send_q();
    wait_drain("end", 1000);
    chk("end_done", upg_done_o, 1);
    wr_before = wr_seen;
    tx_before = tx_seen;
    bq = '{8'h01, 8'h00, 8'h00};
    send_q();
    repeat (300) @(negedge clk);
    chk("done_ignore_wr", wr_seen, wr_before);
    chk("done_ignore_tx", tx_seen, tx_before);
    chk("done_sticky", upg_done_o, 1);

    // Separate run: segment timeout after 2048 idle bit-periods
    do_reset();
    chk("to_rst_done", upg_done_o, 0);
    wr_before = wr_seen;
    tx_before = tx_seen;
    exp_tx.push_back(8'h15);
    bq = '{8'h01, 8'h01, 8'h00, 8'hAA};
    send_q();
    repeat (2048 * 16 - 100) @(negedge clk);
    chk("to_not_early", tx_seen, tx_before);
    wait_drain("timeout", 1000);
    chk("to_no_wr", wr_seen, wr_before);

    repeat (50) @(negedge clk);
    chk("final_tx_left", exp_tx.size(), 0);
    chk("final_wr_left", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
